// File: rtl/vdp_host_pkg.sv
// Shared types and helpers for the VDP host bus responder.
package vdp_host_pkg;

  localparam int unsigned ENTRY_ADDR_W = 16;
  localparam logic [5:0]  STATUS_PREFIX = 6'b011101;

  typedef enum logic [1:0] {
    PORT_DATA = 2'd0,
    PORT_CTRL = 2'd1,
    PORT_HV   = 2'd2,
    PORT_NONE = 2'd3
  } port_sel_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WFULL = 3'd1,
    DRAIN = 3'd2,
    READ  = 3'd3,
    ACK   = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0]              code;
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [15:0]             data;
  } fifo_entry_t;

  function automatic port_sel_e decode_port(input logic [2:0] sel);
    case (sel)
      3'd0:    return PORT_DATA;
      3'd1:    return PORT_CTRL;
      3'd2:    return PORT_HV;
      default: return PORT_NONE;
    endcase
  endfunction

  // A single active byte lane is mirrored into both halves of the word.
  function automatic logic [15:0] byte_lane_data(input logic [15:0] di,
                                                 input logic uds_n,
                                                 input logic lds_n);
    if (!uds_n && lds_n)      return {di[15:8], di[15:8]};
    else if (uds_n && !lds_n) return {di[7:0], di[7:0]};
    else                      return di;
  endfunction

endpackage

// File: rtl/vdp_host_fifo.sv
// Write FIFO carrying data-port writes toward the VRAM engine.
module vdp_host_fifo
  import vdp_host_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t push_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  fifo_entry_t      mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
  end

endmodule

// File: rtl/vdp_host_port.sv
// VDP host bus responder: data/control/HV port decode, command assembly, write FIFO, read handshake.
// Optional byte-lane writes on the data port when HOST_PORT_BYTE_EN is defined.
module vdp_host_port
  import vdp_host_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = ENTRY_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SEL,
  input  logic              RNW,
  input  logic [4:0]        A,
  input  logic [15:0]       DI,
  output logic [15:0]       DO,
  output logic              DTACK_N,
  input  logic [15:0]       HV,
  input  logic [7:0]        STATUS,
  input  logic [7:0]        AUTOINC,
  output logic              REG_WE,
  output logic [4:0]        REG_NUM,
  output logic [7:0]        REG_DATA,
  output logic              FIFO_VALID,
  input  logic              FIFO_READY,
  output logic [3:0]        FIFO_CODE,
  output logic [ADDR_W-1:0] FIFO_ADDR,
  output logic [15:0]       FIFO_DATA,
  output logic              RD_REQ,
  output logic [3:0]        RD_CODE,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic              RD_ACK,
  input  logic [15:0]       RD_DATA
`ifdef HOST_PORT_BYTE_EN
  ,
  input  logic              UDS_N,
  input  logic              LDS_N
`endif
);

  state_e            state;
  logic [5:0]        code;
  logic [ADDR_W-1:0] addr;
  logic              pending;
  logic [15:0]       wdata_q;

  port_sel_e         port_c;
  logic [15:0]       wdata_c;
  logic [ADDR_W-1:0] inc_c;
  logic              data_wr_c;
  logic              push_c;
  logic              pop_c;
  logic              fifo_full;
  logic              fifo_empty;
  fifo_entry_t       push_entry_c;
  fifo_entry_t       head_c;
  logic              unused_c;

  assign port_c = decode_port(A[4:2]);
  assign inc_c  = ADDR_W'(AUTOINC);

`ifdef HOST_PORT_BYTE_EN
  assign wdata_c = byte_lane_data(DI, UDS_N, LDS_N);
`else
  assign wdata_c = DI;
`endif

  // Pushes happen straight from IDLE when there is room, otherwise from WFULL with the latched word.
  assign data_wr_c = (state == IDLE) && SEL && !RNW && (port_c == PORT_DATA);
  assign push_c    = !fifo_full && (data_wr_c || (state == WFULL));
  assign pop_c     = !fifo_empty && FIFO_READY;

  assign push_entry_c.code = code[3:0];
  assign push_entry_c.addr = ENTRY_ADDR_W'(addr);
  assign push_entry_c.data = (state == WFULL) ? wdata_q : wdata_c;

  vdp_host_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst        (RST),
    .push       (push_c),
    .push_entry (push_entry_c),
    .pop        (pop_c),
    .head       (head_c),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign FIFO_VALID = !fifo_empty;
  assign FIFO_CODE  = head_c.code;
  assign FIFO_ADDR  = ADDR_W'(head_c.addr);
  assign FIFO_DATA  = head_c.data;

  assign unused_c = ^{code[5:4], A[1:0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      code     <= '0;
      addr     <= '0;
      pending  <= 1'b0;
      wdata_q  <= '0;
      DO       <= '0;
      DTACK_N  <= 1'b1;
      REG_WE   <= 1'b0;
      REG_NUM  <= '0;
      REG_DATA <= '0;
      RD_REQ   <= 1'b0;
      RD_CODE  <= '0;
      RD_ADDR  <= '0;
    end else begin
      REG_WE <= 1'b0;
      case (state)
        IDLE: begin
          if (SEL) begin
            case (port_c)
              PORT_CTRL: begin
                if (RNW) begin
                  DO      <= {STATUS_PREFIX, fifo_empty, fifo_full, STATUS};
                  pending <= 1'b0;
                end else if (!pending && (DI[15:14] == 2'b10)) begin
                  REG_WE   <= 1'b1;
                  REG_NUM  <= DI[12:8];
                  REG_DATA <= DI[7:0];
                end else if (!pending) begin
                  code[1:0]  <= DI[15:14];
                  addr[13:0] <= DI[13:0];
                  pending    <= 1'b1;
                end else begin
                  code[5:2]   <= DI[7:4];
                  addr[15:14] <= DI[1:0];
                  pending     <= 1'b0;
                end
                state <= ACK;
              end
              PORT_HV: begin
                if (RNW) DO <= HV;
                state <= ACK;
              end
              PORT_DATA: begin
                pending <= 1'b0;
                if (RNW) begin
                  state <= DRAIN;
                end else if (!fifo_full) begin
                  addr  <= addr + inc_c;
                  state <= ACK;
                end else begin
                  wdata_q <= wdata_c;
                  state   <= WFULL;
                end
              end
              default: begin
                if (RNW) DO <= 16'hFFFF;
                state <= ACK;
              end
            endcase
          end
        end
        WFULL: begin
          if (!fifo_full) begin
            addr  <= addr + inc_c;
            state <= ACK;
          end
        end
        // Reads must observe every earlier write, so wait for the FIFO to empty.
        DRAIN: begin
          if (fifo_empty) begin
            RD_REQ  <= 1'b1;
            RD_CODE <= code[3:0];
            RD_ADDR <= addr;
            state   <= READ;
          end
        end
        READ: begin
          if (RD_ACK) begin
            DO     <= RD_DATA;
            RD_REQ <= 1'b0;
            addr   <= addr + inc_c;
            state  <= ACK;
          end
        end
        ACK: begin
          if (SEL) begin
            DTACK_N <= 1'b0;
          end else begin
            DTACK_N <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
